// File: rtl/cnu_iter_ctrl.sv
// Iteration scheduler for the layered LDPC decoder: LLR load, check phase, variable phase,
// with syndrome accumulation and early termination on an all-zero syndrome.
module cnu_iter_ctrl #(
    parameter int unsigned NUM_ROWS    = 8,
    parameter int unsigned NUM_COLS    = 12,
    parameter int unsigned LOAD_CYCLES = 12,
    parameter int unsigned MAX_ITER    = 10,
    parameter int unsigned ROW_W       = 3,
    parameter int unsigned COL_W       = 4,
    parameter int unsigned ITER_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              p_bit,
    output logic              busy,
    output logic              ld_en,
    output logic [COL_W-1:0]  ld_addr,
    output logic              cnu_en,
    output logic [ROW_W-1:0]  row_addr,
    output logic              wb_valid,
    output logic [ROW_W-1:0]  wb_row,
    output logic              vnu_en,
    output logic [COL_W-1:0]  col_addr,
    output logic [ITER_W-1:0] iter_count,
    output logic              done,
    output logic              converged
);

    localparam int unsigned CntW = (COL_W > ROW_W) ? COL_W : ROW_W;

    typedef enum logic [2:0] {
        StIdle, StLoad, StCheck, StDrain, StEval, StVar, StDone
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              conv_q, conv_d;
    logic              synd_q, synd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [ROW_W-1:0]  wb_row_q, wb_row_d;

    logic last_ld, last_row, last_col, max_iter, accept;

    assign last_ld  = (cnt_q == CntW'(LOAD_CYCLES - 1));
    assign last_row = (cnt_q == CntW'(NUM_ROWS - 1));
    assign last_col = (cnt_q == CntW'(NUM_COLS - 1));
    assign max_iter = (iter_q == ITER_W'(MAX_ITER));
    assign accept   = (state_q == StIdle) && (state_d == StLoad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            iter_q     <= '0;
            conv_q     <= 1'b0;
            synd_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_row_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            iter_q     <= iter_d;
            conv_q     <= conv_d;
            synd_q     <= synd_d;
            wb_valid_q <= wb_valid_d;
            wb_row_q   <= wb_row_d;
        end
    end

    // abort outranks every transition, including start in IDLE
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start) state_d = StLoad;
                StLoad:  if (last_ld) state_d = StCheck;
                StCheck: if (last_row) state_d = StDrain;
                StDrain: state_d = StEval;
                StEval:  state_d = (synd_q && !max_iter) ? StVar : StDone;
                StVar:   if (last_col) state_d = StCheck;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) &&
            ((state_q == StLoad) || (state_q == StCheck) || (state_q == StVar))) begin
            cnt_d = cnt_q + 1'b1;
        end

        iter_d = iter_q;
        if (accept) begin
            iter_d = '0;
        end else if ((state_q == StVar) && (state_d == StCheck)) begin
            iter_d = iter_q + 1'b1;
        end

        conv_d = conv_q;
        if (accept) begin
            conv_d = 1'b0;
        end else if (abort && (state_q != StIdle)) begin
            conv_d = 1'b0;
        end else if ((state_q == StEval) && (state_d == StDone)) begin
            conv_d = ~synd_q;
        end

        synd_d = synd_q;
        if ((state_d == StCheck) && (state_q != StCheck)) begin
            synd_d = 1'b0;
        end else if (wb_valid_q && p_bit) begin
            synd_d = 1'b1;
        end

        wb_valid_d = cnu_en & ~abort;
        wb_row_d   = abort ? '0 : row_addr;
    end

    always_comb begin
        busy       = (state_q != StIdle);
        ld_en      = (state_q == StLoad);
        cnu_en     = (state_q == StCheck);
        vnu_en     = (state_q == StVar);
        done       = (state_q == StDone);
        ld_addr    = ld_en ? cnt_q[COL_W-1:0] : '0;
        row_addr   = cnu_en ? cnt_q[ROW_W-1:0] : '0;
        col_addr   = vnu_en ? cnt_q[COL_W-1:0] : '0;
        wb_valid   = wb_valid_q;
        wb_row     = wb_row_q;
        iter_count = iter_q;
        converged  = conv_q;
    end

endmodule
